ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset)
//  to the mouse over the same ps2ck/ps2dt pins used by the packet receiver. Drives both lines
//  open-drain (oe=1 pulls low, oe=0 releases). Asserts tx_active so the receiver ignores bus traffic.
// PARAMETERS
//  INHIBIT_CYCLES  6000     CLOCK cycles clock is held low before request (120 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000   max CLOCK cycles from clock release to ACK (15 ms @ 50 MHz)
//  SYNC_STAGES     2        synchronizer depth on ps2 clk/dat inputs (>=2)
// PORTS
//  CLOCK        in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-high
//  ps2ck_in     in   1  raw PS/2 clock pin level
//  ps2dt_in     in   1  raw PS/2 data pin level
//  ps2ck_oe     out  1  1 = pull PS/2 clock low
//  ps2dt_oe     out  1  1 = pull PS/2 data low
//  tx_data      in   8  command byte, sampled when tx_start accepted
//  tx_start     in   1  one-cycle request; accepted only in IDLE
//  tx_busy      out  1  high from acceptance until done/error pulse cycle inclusive
//  tx_active    out  1  high while any line driven or awaiting ACK/idle (receiver mask)
//  tx_done      out  1  one-cycle pulse: byte sent and ACK (data=0) seen
//  tx_error     out  1  one-cycle pulse: no ACK or timeout
// BEHAVIOUR
//  Reset: ps2ck_oe=0, ps2dt_oe=0, tx_busy=0, tx_active=0, tx_done=0, tx_error=0, state IDLE.
//  Inputs pass SYNC_STAGES flops; ck_fall = one-cycle pulse on synced 1->0 of clock.
//  Frame shift reg loaded on accept: {1'b1 stop, ~^tx_data odd parity, tx_data}; sent LSB first.
//  States:
//   IDLE     : tx_start -> latch frame, cnt=0, -> INHIBIT (oe changes next cycle).
//   INHIBIT  : ps2ck_oe=1; after INHIBIT_CYCLES cycles -> REQ with ps2dt_oe=1 same edge.
//   REQ      : ps2dt_oe=1 (start bit 0), ps2ck_oe=0; timeout counter starts; ck_fall -> SEND.
//   SEND     : on each ck_fall, ps2dt_oe = ~frame[bit]; bit 0..9 (bit 9 = stop, oe=0);
//              first ck_fall in REQ emits bit 0. After stop emitted -> ACK.
//   ACK      : ps2dt_oe=0; next ck_fall samples synced data: 0 -> WAIT_IDLE, 1 -> ERR.
//   WAIT_IDLE: wait synced clk=1 and dat=1 -> DONE.
//   DONE     : tx_done=1 one cycle, -> IDLE.  ERR: tx_error=1 one cycle, both oe=0, -> IDLE.
//  Timeout counter runs REQ..WAIT_IDLE; reaching TIMEOUT_CYCLES in any of them -> ERR
//   (both oe released the same edge ERR is entered). Counter width = $clog2(TIMEOUT_CYCLES+1).
//  tx_start while not IDLE: ignored, no queue, no pulse. tx_start same cycle as DONE/ERR: ignored.
//  Reset asserted mid-frame: next edge both oe=0, all outputs to reset values, no done/error pulse.
//  Device-side clock glitches are not filtered beyond synchronizer; every ck_fall counts.
//  tx_done and tx_error never both high; exactly one pulses per accepted start (absent reset).
// STRUCTURE
//  Shared package ps2_pkg: state enum (IDLE,INHIBIT,REQ,SEND,ACK,WAIT_IDLE,DONE,ERR),
//   command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_DEFAULTS=8'hF6, ACK_BYTE=8'hFA.
//  One sub-module ps2_line_sync: SYNC_STAGES synchronizer for clk+dat, outputs synced levels
//   and ck_fall pulse; reused later by the receiver.
// TESTING
//  Device model generates 12.5 kHz clock after seeing data low with clock released; samples
//   data on its rising edges; drives ACK low on 11th clock unless told otherwise.
//  T1 send 0xF4 -> captured bits 0,0,1,0,1,1,1,1, parity 0, stop 1, ACK -> tx_done once, busy low after.
//  T2 send 0xFF -> parity 1, tx_done; clock low held >= INHIBIT_CYCLES before data driven low.
//  T3 model withholds ACK (data high at 11th clock) for 0xF6 -> tx_error once, no tx_done, oe both 0.
//  T4 model never clocks after REQ -> tx_error exactly TIMEOUT_CYCLES after REQ entry, lines released.
//  T5 reset pulsed during SEND bit 4 -> next cycle ps2ck_oe=ps2dt_oe=0, busy=0, no pulses; new 0xF4 succeeds.
//  T6 second tx_start(0x00) mid-frame of 0xF4 -> ignored; frame on wire is 0xF4, single tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] CMD_ENABLE       = 8'hF4;
  localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;
  localparam logic [7:0] ACK_BYTE         = 8'hFA;

  // Bits shifted out after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data pins and flags falling clock edges.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic ck_raw,
  input  logic dt_raw,
  output logic ck_sync,
  output logic dt_sync,
  output logic ck_fall
);

  logic [SYNC_STAGES-1:0] ck_pipe;
  logic [SYNC_STAGES-1:0] dt_pipe;
  logic                   ck_prev;

  // Shift pin levels through the chain; both lines idle high on the bus.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      ck_pipe <= '1;
      dt_pipe <= '1;
      ck_prev <= 1'b1;
    end else begin
      ck_pipe <= {ck_pipe[SYNC_STAGES-2:0], ck_raw};
      dt_pipe <= {dt_pipe[SYNC_STAGES-2:0], dt_raw};
      ck_prev <= ck_pipe[SYNC_STAGES-1];
    end
  end

  assign ck_sync = ck_pipe[SYNC_STAGES-1];
  assign dt_sync = dt_pipe[SYNC_STAGES-1];
  assign ck_fall = ck_prev & ~ck_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-drain line control.
//
// state     | meaning
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | clock held low to claim the bus
// REQ       | data low (start bit), clock released, waiting for device clock
// SEND      | data/parity/stop bits changed on each device falling clock
// ACK       | data released, next falling clock samples device ACK
// WAIT_IDLE | waiting for both lines to return high
// DONE      | tx_done pulse
// ERR       | tx_error pulse (NACK or timeout)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       ps2ck_in,
  input  logic       ps2dt_in,
  output logic       ps2ck_oe,
  output logic       ps2dt_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_e state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic          ck_sync;
  logic          dt_sync;
  logic          ck_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .ck_raw  (ps2ck_in),
    .dt_raw  (ps2dt_in),
    .ck_sync (ck_sync),
    .dt_sync (dt_sync),
    .ck_fall (ck_fall)
  );

  // Transmit sequencer with registered line enables and status pulses.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      frame     <= '0;
      bit_cnt   <= '0;
      ps2ck_oe  <= 1'b0;
      ps2dt_oe  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            frame     <= tx_frame(tx_data);
            inh_cnt   <= IW'(INHIBIT_CYCLES - 1);
            ps2ck_oe  <= 1'b1;
            tx_busy   <= 1'b1;
            tx_active <= 1'b1;
            state     <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == '0) begin
            ps2ck_oe <= 1'b0;
            ps2dt_oe <= 1'b1;
            tmo_cnt  <= TW'(TIMEOUT_CYCLES - 1);
            state    <= REQ;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end
        REQ, SEND, ACK, WAIT_IDLE: begin
          if (tmo_cnt == '0) begin
            ps2ck_oe  <= 1'b0;
            ps2dt_oe  <= 1'b0;
            tx_error  <= 1'b1;
            tx_active <= 1'b0;
            state     <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
            if (state == REQ || state == SEND) begin
              if (ck_fall) begin
                ps2dt_oe <= ~frame[0];
                frame    <= {1'b0, frame[9:1]};
                bit_cnt  <= (state == REQ) ? 4'd1 : bit_cnt + 1'b1;
                if (state == REQ) state <= SEND;
                else if (bit_cnt == 4'd9) state <= ACK;
              end
            end else if (state == ACK) begin
              ps2dt_oe <= 1'b0;
              if (ck_fall) begin
                if (dt_sync) begin
                  tx_error  <= 1'b1;
                  tx_active <= 1'b0;
                  state     <= ERR;
                end else begin
                  state <= WAIT_IDLE;
                end
              end
            end else if (ck_sync && dt_sync) begin
              tx_done   <= 1'b1;
              tx_active <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE, ERR: begin
          ps2ck_oe  <= 1'b0;
          ps2dt_oe  <= 1'b0;
          tx_busy   <= 1'b0;
          tx_active <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device plus frame-level expectations.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TMO = 1500;
  localparam int HP  = 20;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b1;
  logic       ps2ck_in, ps2dt_in;
  logic       ps2ck_oe, ps2dt_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_active, tx_done, tx_error;

  logic        dev_ck_low = 1'b0;
  logic        dev_dt_low = 1'b0;
  bit          dev_nack = 0, dev_noclock = 0, dev_busy = 0;
  int          dev_fall = 0;
  logic [10:0] dev_bits = '0;

  int n_checks = 0, n_errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, overlap_cnt = 0;
  int cyc = 0, ck_run = 0, last_ck_run = 0, dt_rise_cyc = 0, err_rise_cyc = 0;
  logic prev_dt = 1'b0, prev_err = 1'b0;
  int d0, e0;

  assign ps2ck_in = ~(ps2ck_oe | dev_ck_low);
  assign ps2dt_in = ~(ps2dt_oe | dev_dt_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .CLOCK(CLOCK), .reset(reset), .ps2ck_in(ps2ck_in), .ps2dt_in(ps2dt_in),
    .ps2ck_oe(ps2ck_oe), .ps2dt_oe(ps2dt_oe), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_active(tx_active), .tx_done(tx_done), .tx_error(tx_error)
  );

  initial forever #5 CLOCK = ~CLOCK;

  // Device: clocks a frame once data is low with clock released, samples on rising edges.
  initial begin : device
    forever begin
      @(negedge CLOCK);
      if (!dev_noclock && !reset && ps2ck_in === 1'b1 && ps2dt_in === 1'b0) begin
        dev_busy = 1;
        dev_bits[0] = ps2dt_in;
        repeat ($urandom_range(2, 30)) @(negedge CLOCK);
        for (int i = 1; i <= 11; i++) begin
          dev_ck_low = 1'b1;
          dev_fall = i;
          repeat (HP) @(negedge CLOCK);
          dev_ck_low = 1'b0;
          if (i == 11) dev_dt_low = 1'b0;
          else dev_bits[i] = ps2dt_in;
          if (i == 10 && !dev_nack) dev_dt_low = 1'b1;
          repeat (HP) @(negedge CLOCK);
        end
        dev_fall = 0;
        dev_busy = 0;
      end
    end
  end

  // Observer: pulse counts, clock-inhibit run length and event timestamps.
  always @(negedge CLOCK) begin
    cyc++;
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
    if (ps2ck_oe === 1'b1 && ps2dt_oe === 1'b1) overlap_cnt++;
    if (ps2ck_oe === 1'b1) ck_run++;
    else begin
      if (ck_run > 0) last_ck_run = ck_run;
      ck_run = 0;
    end
    if (ps2dt_oe === 1'b1 && prev_dt !== 1'b1) dt_rise_cyc = cyc;
    if (tx_error === 1'b1 && prev_err !== 1'b1) err_rise_cyc = cyc;
    prev_dt = ps2dt_oe;
    prev_err = tx_error;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic wait_dev_idle(input string tag);
    int n;
    n = 0;
    while (dev_busy && n < 2000) begin tick(); n++; end
    if (n >= 2000) check_val({tag, "_dev_idle_timeout"}, 0, 1);
  endtask

  task automatic start_frame(input logic [7:0] b, input string tag);
    wait_dev_idle(tag);
    tick();
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data = 8'($urandom);
    check_val({tag, "_busy_after_start"}, 32'(tx_busy), 1);
  endtask

  task automatic finish_frame(input logic [7:0] b, input bit exp_ok, input bit chk_bits,
                              input string tag);
    int n;
    bit par;
    logic [10:0] exp_bits;
    n = 0;
    while (tx_done !== 1'b1 && tx_error !== 1'b1 && n < 4000) begin tick(); n++; end
    if (n >= 4000) check_val({tag, "_no_pulse"}, 0, 1);
    else begin
      check_val({tag, "_busy_at_pulse"}, 32'(tx_busy), 1);
      check_val({tag, "_oe_at_pulse"}, {30'd0, ps2ck_oe, ps2dt_oe}, 0);
    end
    wait_dev_idle(tag);
    repeat (5) tick();
    check_val({tag, "_done_count"}, done_cnt - d0, exp_ok ? 1 : 0);
    check_val({tag, "_error_count"}, err_cnt - e0, exp_ok ? 0 : 1);
    check_val({tag, "_idle_outputs"}, {28'd0, ps2ck_oe, ps2dt_oe, tx_busy, tx_active}, 0);
    if (chk_bits) begin
      par = ($countones(b) % 2 == 0);
      exp_bits = {1'b1, par, b, 1'b0};
      check_val({tag, "_wire_bits"}, 32'(dev_bits), 32'(exp_bits));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ok, input string tag);
    start_frame(b, tag);
    finish_frame(b, exp_ok, 1, tag);
  endtask

  initial begin : stimulus
    int n;
    logic [7:0] rb;
    bit nk;

    repeat (5) tick();
    reset = 1'b0;
    tick();
    check_val("reset_outputs",
              {26'd0, ps2ck_oe, ps2dt_oe, tx_busy, tx_active, tx_done, tx_error}, 0);

    // T1 enable reporting
    send_byte(8'hF4, 1, "t1");

    // T2 reset command, parity 1, inhibit length
    send_byte(8'hFF, 1, "t2");
    check_val("t2_inhibit_len_ge", 32'(last_ck_run >= INH), 1);

    // T3 device withholds ACK
    dev_nack = 1;
    send_byte(8'hF6, 0, "t3");
    dev_nack = 0;

    // T4 device never clocks: timeout measured from REQ entry
    dev_noclock = 1;
    start_frame(8'hF4, "t4");
    finish_frame(8'hF4, 0, 0, "t4");
    check_val("t4_timeout_cycles", err_rise_cyc - dt_rise_cyc, TMO);
    dev_noclock = 0;

    // T5 reset during bit 4
    start_frame(8'hF4, "t5");
    n = 0;
    while (dev_fall != 5 && n < 3000) begin tick(); n++; end
    if (n >= 3000) check_val("t5_reach_bit4", 0, 1);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_val("t5_after_reset",
              {26'd0, ps2ck_oe, ps2dt_oe, tx_busy, tx_active, tx_done, tx_error}, 0);
    reset = 1'b0;
    wait_dev_idle("t5");
    repeat (5) tick();
    check_val("t5_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    send_byte(8'hF4, 1, "t5_retry");

    // T6 second start mid-frame is ignored
    start_frame(8'hF4, "t6");
    n = 0;
    while (dev_fall != 4 && n < 3000) begin tick(); n++; end
    if (n >= 3000) check_val("t6_reach_bit3", 0, 1);
    tx_data = 8'h00;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    finish_frame(8'hF4, 1, 1, "t6");

    // Random bytes with occasional NACK
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      nk = ($urandom_range(0, 3) == 0);
      dev_nack = nk;
      send_byte(rb, !nk, $sformatf("rnd%0d", k));
    end
    dev_nack = 0;

    check_val("never_done_and_error", both_cnt, 0);
    check_val("no_ck_dt_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
